// File: rtl/hawk_att_lkup_cache_if.sv
// rtl/hawk_att_lkup_cache_if.sv - lookup, invalidate and AXI-read signal bundle for the ATT lookup cache
interface hawk_att_lkup_cache_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 512,
  parameter int LEN_W  = 8
) ();
  logic                 lkup_valid_i;
  logic [ADDR_W-13:0]   lkup_hppa_i;
  logic                 lkup_ready_o;
  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [63:0]          rsp_entry_o;
  logic                 rsp_hit_o;
  logic                 rsp_err_o;
  logic                 inv_valid_i;
  logic [ADDR_W-1:0]    inv_addr_i;
  logic                 ar_valid_o;
  logic [ADDR_W-1:0]    ar_addr_o;
  logic [LEN_W-1:0]     ar_len_o;
  logic                 ar_ready_i;
  logic                 r_valid_i;
  logic [DATA_W-1:0]    r_data_i;
  logic [1:0]           r_resp_i;
  logic                 r_last_i;
  logic                 r_ready_o;
  logic [31:0]          hit_cnt_o;
  logic [31:0]          miss_cnt_o;

  modport slave (
    input  lkup_valid_i, lkup_hppa_i, rsp_ready_i, inv_valid_i, inv_addr_i,
           ar_ready_i, r_valid_i, r_data_i, r_resp_i, r_last_i,
    output lkup_ready_o, rsp_valid_o, rsp_entry_o, rsp_hit_o, rsp_err_o,
           ar_valid_o, ar_addr_o, ar_len_o, r_ready_o, hit_cnt_o, miss_cnt_o
  );

  modport master (
    output lkup_valid_i, lkup_hppa_i, rsp_ready_i, inv_valid_i, inv_addr_i,
           ar_ready_i, r_valid_i, r_data_i, r_resp_i, r_last_i,
    input  lkup_ready_o, rsp_valid_o, rsp_entry_o, rsp_hit_o, rsp_err_o,
           ar_valid_o, ar_addr_o, ar_len_o, r_ready_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/hawk_att_lkup_cache.sv
// rtl/hawk_att_lkup_cache.sv - fully-associative ATT block cache mapping host page number to AttEntry
module hawk_att_lkup_cache #(
  parameter int                NUM_LINES = 4,
  parameter int                ADDR_W    = 64,
  parameter int                DATA_W    = 512,
  parameter int                LEN_W     = 8,
  parameter logic [ADDR_W-1:0] ATT_BASE  = 64'hFFF6100000
) (
  input logic                    clk_i,
  input logic                    rst_i,
  hawk_att_lkup_cache_if.slave   bus
);
  localparam int TAG_W = ADDR_W - 6;
  localparam int HP_W  = ADDR_W - 12;
  localparam int PTR_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_CMP, S_AR, S_RWAIT, S_RSP} state_t;
  state_t r_state, w_next;

  logic [HP_W-1:0]    r_hppa;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tag [NUM_LINES];
  logic [DATA_W-1:0]  r_data [NUM_LINES];
  logic               r_stale;
  logic [PTR_W-1:0]   r_rr;
  logic [31:0]        r_hit_cnt, r_miss_cnt;
  logic [63:0]        r_rsp_entry;
  logic               r_rsp_hit, r_rsp_err;

  logic [ADDR_W-1:0]  w_entry_addr;
  logic [TAG_W-1:0]   w_tag, w_inv_tag;
  logic [2:0]         w_idx;
  logic               w_inv_match, w_stale_now, w_last, w_fill, w_hit;
  logic [63:0]        w_hit_entry;
  logic [PTR_W-1:0]   w_fill_line;
  logic               w_unused;

  assign w_entry_addr = ATT_BASE + ADDR_W'({r_hppa, 3'b000});
  assign w_tag        = w_entry_addr[ADDR_W-1:6];
  assign w_idx        = r_hppa[2:0];
  assign w_inv_tag    = bus.inv_addr_i[ADDR_W-1:6];
  assign w_inv_match  = bus.inv_valid_i && (w_inv_tag == w_tag);
  assign w_stale_now  = r_stale || w_inv_match;
  assign w_last       = bus.r_valid_i && bus.r_last_i;
  assign w_fill       = (r_state == S_RWAIT) && w_last && (bus.r_resp_i == 2'b00) && !w_stale_now;
  assign w_unused     = ^{bus.inv_addr_i[5:0], w_entry_addr[5:0]};

  always_comb begin
    w_hit       = 1'b0;
    w_hit_entry = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (r_valid[i] && (r_tag[i] == w_tag)) begin
        w_hit       = 1'b1;
        w_hit_entry = r_data[i][{w_idx, 6'b0} +: 64];
      end
    end
  end

  // Lowest-numbered free line wins; round-robin victim only when all lines are valid
  always_comb begin
    w_fill_line = r_rr;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (!r_valid[i]) w_fill_line = PTR_W'(i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    bus.lkup_ready_o = 1'b0;
    bus.ar_valid_o   = 1'b0;
    bus.r_ready_o    = 1'b0;
    bus.rsp_valid_o  = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.lkup_ready_o = 1'b1;
        if (bus.lkup_valid_i) w_next = S_CMP;
      end
      S_CMP:   w_next = (w_hit && !w_inv_match) ? S_RSP : S_AR;
      S_AR: begin
        bus.ar_valid_o = 1'b1;
        if (bus.ar_ready_i) w_next = S_RWAIT;
      end
      S_RWAIT: begin
        bus.r_ready_o = 1'b1;
        if (w_last) begin
          if (bus.r_resp_i != 2'b00) w_next = S_RSP;
          else if (w_stale_now)      w_next = S_AR;
          else                       w_next = S_RSP;
        end
      end
      S_RSP: begin
        bus.rsp_valid_o = 1'b1;
        if (bus.rsp_ready_i) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_hppa      <= '0;
      r_valid     <= '0;
      r_stale     <= 1'b0;
      r_rr        <= '0;
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_rsp_entry <= '0;
      r_rsp_hit   <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && bus.lkup_valid_i) r_hppa <= bus.lkup_hppa_i;
      for (int i = 0; i < NUM_LINES; i++) begin
        if (bus.inv_valid_i && (r_tag[i] == w_inv_tag)) r_valid[i] <= 1'b0;
      end
      case (r_state)
        S_CMP: begin
          if (w_hit && !w_inv_match) begin
            if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            r_rsp_entry <= w_hit_entry;
            r_rsp_hit   <= 1'b1;
            r_rsp_err   <= 1'b0;
          end else begin
            if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            r_stale <= 1'b0;
          end
        end
        S_AR: if (w_inv_match) r_stale <= 1'b1;
        S_RWAIT: begin
          if (w_last) begin
            if (bus.r_resp_i != 2'b00) begin
              r_rsp_entry <= '0;
              r_rsp_hit   <= 1'b0;
              r_rsp_err   <= 1'b1;
            end else if (w_stale_now) begin
              r_stale <= 1'b0;
            end else begin
              r_valid[w_fill_line] <= 1'b1;
              r_rr        <= (r_rr == PTR_W'(NUM_LINES - 1)) ? '0 : r_rr + 1'b1;
              r_rsp_entry <= bus.r_data_i[{w_idx, 6'b0} +: 64];
              r_rsp_hit   <= 1'b0;
              r_rsp_err   <= 1'b0;
            end
          end else if (w_inv_match) begin
            r_stale <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Line payloads need no reset; the valid bits guard them
  always_ff @(posedge clk_i) begin
    if (w_fill) begin
      r_tag[w_fill_line]  <= w_tag;
      r_data[w_fill_line] <= bus.r_data_i;
    end
  end

  assign bus.ar_addr_o   = (r_state == S_AR) ? {w_tag, 6'b0} : '0;
  assign bus.ar_len_o    = '0;
  assign bus.rsp_entry_o = r_rsp_entry;
  assign bus.rsp_hit_o   = r_rsp_hit;
  assign bus.rsp_err_o   = r_rsp_err;
  assign bus.hit_cnt_o   = r_hit_cnt;
  assign bus.miss_cnt_o  = r_miss_cnt;
endmodule
